// File: rtl/baseline_subtract.sv
// Baseline removal: delays the raw sample stream to line up with the median
// stage output and subtracts it. Optional macro BASELINE_SAT_EN saturates y.
`ifndef DATA_LENGTH
`define DATA_LENGTH 16
`endif
`ifndef LOG_WMAX
`define LOG_WMAX 5
`endif

module baseline_subtract #(
  parameter int DATA_LENGTH = `DATA_LENGTH,
  parameter int LOG_WMAX    = `LOG_WMAX,
  parameter int PIPE_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] X,
  input  logic [DATA_LENGTH-1:0] median,
  input  logic [LOG_WMAX-1:0]    W,
  output logic [DATA_LENGTH-1:0] y,
  output logic                   valid
);

  localparam int DEPTH = 1 << LOG_WMAX;
  localparam int CW    = LOG_WMAX + 2;

  typedef enum logic {FILL, RUN} state_t;

  logic [DATA_LENGTH-1:0] r_buf [DEPTH];
  logic [LOG_WMAX-1:0]    r_wp;
  logic [LOG_WMAX-1:0]    r_wq;
  logic [CW-1:0]          r_cnt;
  logic                   r_first;
  state_t                 r_state;
  logic [DATA_LENGTH-1:0] r_y;
  logic                   r_valid;

  logic [LOG_WMAX-1:0]    w_d;
  logic [LOG_WMAX-1:0]    w_rp;
  logic [CW-1:0]          w_fill_len;
  logic [CW-1:0]          w_cnt_nx;
  logic [DATA_LENGTH-1:0] w_xd;
  logic [DATA_LENGTH-1:0] w_y;

  assign w_d        = (r_wq >> 1) + LOG_WMAX'(PIPE_LAT);
  assign w_fill_len = CW'(w_d) + CW'(r_wq);
  assign w_cnt_nx   = (r_cnt >= w_fill_len) ? r_cnt : r_cnt + CW'(1);
  assign w_rp       = r_wp - w_d;
  assign w_xd       = r_buf[w_rp];

`ifdef BASELINE_SAT_EN
  logic signed [DATA_LENGTH:0] w_diff;

  assign w_diff = $signed({1'b0, w_xd}) - $signed({1'b0, median});

  always_comb begin
    w_y = w_diff[DATA_LENGTH-1:0];
    if (w_diff[DATA_LENGTH] != w_diff[DATA_LENGTH-1])
      w_y = w_diff[DATA_LENGTH] ? {1'b1, {(DATA_LENGTH-1){1'b0}}}
                                : {1'b0, {(DATA_LENGTH-1){1'b1}}};
  end
`else
  // Wrapping result only needs the low bits of the widened difference.
  assign w_y = w_xd - median;
`endif

  // Sample storage is deliberately unreset; valid gating hides stale entries.
  always_ff @(posedge clk) begin
    r_buf[r_wp] <= X;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_wq    <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_state <= FILL;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wp <= r_wp + LOG_WMAX'(1);
      if (r_first) begin
        // First edge after reset adopts W as part of the fill, not a restart.
        r_first <= 1'b0;
        r_wq    <= W;
        r_cnt   <= CW'(1);
        r_state <= FILL;
        r_y     <= '0;
        r_valid <= 1'b0;
      end else if (W != r_wq) begin
        r_wq    <= W;
        r_cnt   <= '0;
        r_state <= FILL;
        r_y     <= '0;
        r_valid <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nx;
        case (r_state)
          FILL: begin
            if (r_wq != '0 && w_cnt_nx == w_fill_len) begin
              r_valid <= 1'b1;
              r_y     <= w_y;
              r_state <= RUN;
            end else begin
              r_valid <= 1'b0;
              r_y     <= '0;
            end
          end
          RUN: begin
            r_valid <= 1'b1;
            r_y     <= w_y;
          end
          default: begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_state <= FILL;
          end
        endcase
      end
    end
  end

  assign y     = r_y;
  assign valid = r_valid;

endmodule

// File: tb/tb_baseline_subtract.sv
// Self-checking bench for baseline_subtract against a sample-history model.
module tb_baseline_subtract;

  localparam int DL = 16;
  localparam int LW = 5;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DL-1:0] X;
  logic [DL-1:0] median;
  logic [LW-1:0] W;
  logic [DL-1:0] y;
  logic          valid;

  int checks   = 0;
  int failures = 0;

  logic [DL-1:0] hist[$];
  int            n;
  int            restart;
  int            wq;
  bit            first;
  logic [DL-1:0] exp_y;
  logic          exp_v;

  baseline_subtract #(.DATA_LENGTH(DL), .LOG_WMAX(LW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .X(X), .median(median), .W(W),
    .y(y), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DL-1:0] ref_y(input int xd, input int m);
    int d;
    d = xd - m;
`ifdef BASELINE_SAT_EN
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
`endif
    return DL'(d);
  endfunction

  task automatic check(input string tag, input logic [DL-1:0] got,
                       input logic [DL-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected outputs after edge n, from the spec's timing rules on the history.
  task automatic model_edge();
    int d, fl;
    n++;
    if (first) begin
      first   = 1'b0;
      wq      = int'(W);
      restart = n - 1;
      exp_v   = 1'b0;
      exp_y   = '0;
    end else if (int'(W) != wq) begin
      wq      = int'(W);
      restart = n;
      exp_v   = 1'b0;
      exp_y   = '0;
    end else begin
      d  = (wq / 2) + PL;
      fl = d + wq;
      if (wq != 0 && (n - restart) >= fl) begin
        exp_v = 1'b1;
        exp_y = ref_y(int'(hist[n - 1 - d]), int'(median));
      end else begin
        exp_v = 1'b0;
        exp_y = '0;
      end
    end
    hist.push_back(X);
  endtask

  task automatic step(input logic [DL-1:0] x, input logic [DL-1:0] m,
                      input logic [LW-1:0] w);
    X = x; median = m; W = w;
    @(posedge clk);
    model_edge();
    #1;
    check("valid", {{(DL-1){1'b0}}, valid}, {{(DL-1){1'b0}}, exp_v});
    check("y", y, exp_y);
  endtask

  task automatic model_reset();
    n = 0; restart = 0; wq = 0; first = 1'b1;
    hist.delete();
  endtask

  initial begin
    logic [LW-1:0] wr;
    reset = 1'b0; X = '0; median = '0; W = 5'd5;
    model_reset();
    #2;
    check("reset_y", y, '0);
    check("reset_valid", {{(DL-1){1'b0}}, valid}, '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Ramp X=1,2,3.. across the buffer wrap.
    for (int i = 1; i <= 45; i++) begin
      step(DL'(i), '0, 5'd5);
      if (i == 8) check("ramp_edge8_valid", {{(DL-1){1'b0}}, valid}, '0);
      if (i == 9) check("ramp_edge9_y", y, 16'd5);
      if (i == 40) check("ramp_wrap_y", y, 16'd36);
    end

    // Extremes of the difference.
    for (int i = 0; i < 6; i++) step(16'hFFFF, 16'h0000, 5'd5);
`ifdef BASELINE_SAT_EN
    check("sat_pos", y, 16'h7FFF);
`else
    check("wrap_pos", y, 16'hFFFF);
`endif
    for (int i = 0; i < 6; i++) step(16'h0000, 16'hFFFF, 5'd5);
`ifdef BASELINE_SAT_EN
    check("sat_neg", y, 16'h8000);
`else
    check("wrap_neg", y, 16'h0001);
`endif

    for (int i = 0; i < 40; i++) step(DL'($urandom), DL'($urandom), 5'd5);

    // Window change 5 -> 9 while running.
    for (int i = 0; i <= 25; i++) begin
      step(DL'($urandom), DL'($urandom_range(0, 300)), 5'd9);
      if (i == 0)  check("wchg_valid0", {{(DL-1){1'b0}}, valid}, '0);
      if (i == 14) check("wchg_edge14_valid", {{(DL-1){1'b0}}, valid}, '0);
      if (i == 15) check("wchg_edge15_valid", {{(DL-1){1'b0}}, valid}, 16'd1);
    end

    // Random window changes.
    wr = 5'd9;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) wr = LW'($urandom_range(0, 31));
      step(DL'($urandom), DL'($urandom), wr);
    end

    for (int i = 0; i < 50; i++) step(DL'($urandom), DL'($urandom), 5'd0);
    check("w0_valid", {{(DL-1){1'b0}}, valid}, '0);
    check("w0_y", y, '0);

    for (int i = 0; i < 20; i++) step(DL'($urandom), 16'd10, 5'd5);
    check("prereset_valid", {{(DL-1){1'b0}}, valid}, 16'd1);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async_y", y, '0);
    check("async_valid", {{(DL-1){1'b0}}, valid}, '0);
    #1 reset = 1'b1;
    model_reset();

    for (int i = 1; i <= 20; i++) begin
      step(16'd100, 16'd100, 5'd5);
      if (i == 8) check("const_edge8_valid", {{(DL-1){1'b0}}, valid}, '0);
      if (i == 9) check("const_edge9_valid", {{(DL-1){1'b0}}, valid}, 16'd1);
      if (i == 15) check("const_y", y, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
